serial_add_sequencer: RTL

//  Upstream control/datapath stage for the Mealy serial adder. Latches two WIDTH-bit

---
 rtl/serial_add_sequencer_pkg.sv | 17 +
 rtl/serial_add_sequencer_piso_shift_reg.sv | 28 ++
 rtl/serial_add_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the serial-datapath blocks: FSM state encoding and
// the bit-counter width helper.
package serial_add_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Counter must be able to hold WIDTH itself, hence the extra bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_add_sequencer_piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first, zero fill from the MSB.
module piso_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] par_in,
   output logic             ser_out
);

   logic [WIDTH-1:0] q;

   // Load has priority over shift; reset clears the register.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= par_in;
      end else if (shift) begin
         q <= {1'b0, q[WIDTH-1:1]};
      end
   end

   assign ser_out = q[0];

endmodule

// File: rtl/serial_add_sequencer.sv
// Control/datapath stage feeding a Mealy serial adder: latches two operands,
// clears the adder carry, streams bits LSB-first and assembles the sum.
module serial_add_sequencer
   import serial_add_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic             S_in,
   output logic             A_out,
   output logic             B_out,
   output logic             AdderEn,
   output logic             AdderRst,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] sum_next;
   logic             load;
   logic             shift;
   logic             last_bit;
   logic             a_lsb;
   logic             b_lsb;

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   assign sum_next = {S_in, sum_q[WIDTH-1:1]};

   piso_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
      .clk     (Clock),
      .rst     (Reset),
      .load    (load),
      .shift   (shift),
      .par_in  (OpA),
      .ser_out (a_lsb)
   );

   piso_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
      .clk     (Clock),
      .rst     (Reset),
      .load    (load),
      .shift   (shift),
      .par_in  (OpB),
      .ser_out (b_lsb)
   );

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Bit counter, serial sum capture and result register.
   // The final sum bit arrives on the same edge that leaves SHIFT, so Result
   // is loaded from the shifted value to be visible in the DONE cycle.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt      <= '0;
         sum_q    <= '0;
         result_q <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (Start) begin
                  cnt <= '0;
               end
            end
            ST_SHIFT: begin
               sum_q <= sum_next;
               cnt   <= cnt + CNT_W'(1);
               if (last_bit) begin
                  result_q <= sum_next;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and Moore output decode; outputs held low while Reset is high.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      shift      = 1'b0;
      A_out      = 1'b0;
      B_out      = 1'b0;
      AdderEn    = 1'b0;
      AdderRst   = 1'b0;
      Busy       = 1'b0;
      Done       = 1'b0;
      Result     = '0;
      unique case (state)
         ST_IDLE: begin
            if (Start) begin
               load       = 1'b1;
               next_state = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            AdderRst   = 1'b1;
            Busy       = 1'b1;
            next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            shift   = 1'b1;
            AdderEn = 1'b1;
            Busy    = 1'b1;
            A_out   = a_lsb;
            B_out   = b_lsb;
            if (last_bit) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            Done       = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
      if (!Reset) begin
         Result = result_q;
      end else begin
         load     = 1'b0;
         shift    = 1'b0;
         A_out    = 1'b0;
         B_out    = 1'b0;
         AdderEn  = 1'b0;
         AdderRst = 1'b0;
         Busy     = 1'b0;
         Done     = 1'b0;
      end
   end

endmodule
